// File: rtl/lab3_mem_bank_pkg.sv
// Shared types and constants for the banked memory request router: message layouts,
// message type codes and the bank-id width helper.
package lab3_mem_bank_pkg;

  localparam int unsigned REQ_W  = 77;
  localparam int unsigned RESP_W = 47;

  // Bit position of addr inside a flattened mem_req_4B message (above len and data).
  localparam int unsigned REQ_ADDR_LSB = 34;

  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  msg_type;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  function automatic int unsigned bank_id_width(input int unsigned num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage

// File: rtl/lab3_mem_BankOrderQueue.sv
// Circular FIFO of bank ids recording the order in which requests were issued, so responses
// can be returned to the processor in request order.
module lab3_mem_BankOrderQueue #(
  parameter int unsigned p_depth = 4,
  parameter int unsigned p_width = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enq_val,
  input  logic [p_width-1:0] enq_data,
  input  logic               deq_val,
  output logic               full,
  output logic               empty,
  output logic [p_width-1:0] head
);

  localparam int unsigned PTR_W = (p_depth > 1) ? $clog2(p_depth) : 1;
  localparam int unsigned CNT_W = $clog2(p_depth + 1);

  logic [p_width-1:0] entries [p_depth];
  logic [PTR_W-1:0]   enq_ptr;
  logic [PTR_W-1:0]   deq_ptr;
  logic [CNT_W-1:0]   count;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(p_depth - 1)) ? '0 : ptr + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enq_ptr <= '0;
      deq_ptr <= '0;
      count   <= '0;
    end else begin
      if (enq_val) enq_ptr <= ptr_next(enq_ptr);
      if (deq_val) deq_ptr <= ptr_next(deq_ptr);
      if (enq_val && !deq_val)      count <= count + CNT_W'(1);
      else if (!enq_val && deq_val) count <= count - CNT_W'(1);
    end
  end

  // Payload storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (enq_val) entries[enq_ptr] <= enq_data;
  end

  assign full  = (count == CNT_W'(p_depth));
  assign empty = (count == '0);
  assign head  = entries[deq_ptr];

  a_no_pop_empty: assert property (@(posedge clk) disable iff (reset) !(deq_val && empty));
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(enq_val && full));

endmodule

// File: rtl/lab3_mem_bank_req_router.sv
// Splits one processor memory port across p_num_banks cache banks by address bank bits and
// returns bank responses to the processor strictly in request order.
module lab3_mem_bank_req_router
  import lab3_mem_bank_pkg::*;
#(
  parameter int unsigned p_num_banks    = 4,
  parameter int unsigned p_bank_shamt   = 4,
  parameter int unsigned p_num_inflight = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            procreq_val,
  output logic                            procreq_rdy,
  input  logic [REQ_W-1:0]                procreq_msg,
  output logic                            procresp_val,
  input  logic                            procresp_rdy,
  output logic [RESP_W-1:0]               procresp_msg,
  output logic [p_num_banks-1:0]          bankreq_val,
  input  logic [p_num_banks-1:0]          bankreq_rdy,
  output logic [REQ_W*p_num_banks-1:0]    bankreq_msg,
  input  logic [p_num_banks-1:0]          bankresp_val,
  output logic [p_num_banks-1:0]          bankresp_rdy,
  input  logic [RESP_W*p_num_banks-1:0]   bankresp_msg
);

  localparam int unsigned BID_W = bank_id_width(p_num_banks);

  logic [BID_W-1:0]  bid;
  logic [BID_W-1:0]  head_bid;
  logic              oq_full;
  logic              oq_empty;
  logic              req_fire;
  logic              resp_fire;
  logic [RESP_W-1:0] resp_arr [p_num_banks];

  assign bid = procreq_msg[REQ_ADDR_LSB + p_bank_shamt +: BID_W];

  // Every bank sees the request unmodified; only the valid is steered.
  assign bankreq_msg = {p_num_banks{procreq_msg}};

  for (genvar g = 0; g < p_num_banks; g++) begin : g_resp_unpack
    assign resp_arr[g] = bankresp_msg[g*RESP_W +: RESP_W];
  end

  always_comb begin
    bankreq_val  = '0;
    bankresp_rdy = '0;
    procresp_val = 1'b0;
    procresp_msg = '0;
    procreq_rdy  = bankreq_rdy[bid] && !oq_full;
    for (int i = 0; i < p_num_banks; i++) begin
      bankreq_val[i] = procreq_val && (bid == BID_W'(i)) && !oq_full;
    end
    // Only the oldest outstanding bank may return; others are held off.
    if (!oq_empty) begin
      procresp_val           = bankresp_val[head_bid];
      procresp_msg           = resp_arr[head_bid];
      bankresp_rdy[head_bid] = procresp_rdy;
    end
  end

  assign req_fire  = procreq_val && procreq_rdy;
  assign resp_fire = procresp_val && procresp_rdy;

  lab3_mem_BankOrderQueue #(
    .p_depth (p_num_inflight),
    .p_width (BID_W)
  ) u_order_queue (
    .clk      (clk),
    .reset    (reset),
    .enq_val  (req_fire),
    .enq_data (bid),
    .deq_val  (resp_fire),
    .full     (oq_full),
    .empty    (oq_empty),
    .head     (head_bid)
  );

  a_no_x_ctrl: assert property (@(posedge clk) disable iff (reset)
                                !$isunknown({procreq_val, procresp_rdy}));

endmodule

// File: tb/tb_lab3_mem_bank_req_router.sv
// Bench for lab3_mem_bank_req_router: directed vector table, hand sequences for stall and
// async reset, then a random val/rdy run against an in-order response model.
module tb_lab3_mem_bank_req_router;
  import lab3_mem_bank_pkg::*;

  localparam int unsigned NB = 4;
  localparam int unsigned NT = 500;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   procreq_val;
  logic                   procreq_rdy;
  logic [REQ_W-1:0]       procreq_msg;
  logic                   procresp_val;
  logic                   procresp_rdy;
  logic [RESP_W-1:0]      procresp_msg;
  logic [NB-1:0]          bankreq_val;
  logic [NB-1:0]          bankreq_rdy;
  logic [REQ_W*NB-1:0]    bankreq_msg;
  logic [NB-1:0]          bankresp_val;
  logic [NB-1:0]          bankresp_rdy;
  logic [RESP_W*NB-1:0]   bankresp_msg;

  int n_vec  = 0;
  int n_miss = 0;

  lab3_mem_bank_req_router #(
    .p_num_banks    (NB),
    .p_bank_shamt   (4),
    .p_num_inflight (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .procreq_val  (procreq_val),
    .procreq_rdy  (procreq_rdy),
    .procreq_msg  (procreq_msg),
    .procresp_val (procresp_val),
    .procresp_rdy (procresp_rdy),
    .procresp_msg (procresp_msg),
    .bankreq_val  (bankreq_val),
    .bankreq_rdy  (bankreq_rdy),
    .bankreq_msg  (bankreq_msg),
    .bankresp_val (bankresp_val),
    .bankresp_rdy (bankresp_rdy),
    .bankresp_msg (bankresp_msg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        pv;
    logic [31:0] addr;
    logic [3:0]  brdy;
    logic [3:0]  bval;
    logic        prdy;
    logic        e_prdy;
    logic [3:0]  e_bqv;
    logic        e_pval;
    logic [3:0]  e_brrdy;
    int          e_hb;
  } vec_t;

  vec_t tv[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk_vec(input logic pv, input logic [31:0] addr, input logic [3:0] brdy,
                                  input logic [3:0] bval, input logic prdy, input logic e_prdy,
                                  input logic [3:0] e_bqv, input logic e_pval,
                                  input logic [3:0] e_brrdy, input int e_hb);
    vec_t v;
    v.pv = pv; v.addr = addr; v.brdy = brdy; v.bval = bval; v.prdy = prdy;
    v.e_prdy = e_prdy; v.e_bqv = e_bqv; v.e_pval = e_pval; v.e_brrdy = e_brrdy; v.e_hb = e_hb;
    return v;
  endfunction

  function automatic logic [REQ_W-1:0] mk_req(input logic [2:0] t, input logic [7:0] op,
                                              input logic [31:0] addr, input logic [31:0] data);
    mem_req_4B_t r;
    r.msg_type = t; r.opaque = op; r.addr = addr; r.len = 2'd0; r.data = data;
    return r;
  endfunction

  function automatic logic [RESP_W-1:0] tbl_resp(input int b);
    mem_resp_4B_t p;
    p.msg_type = MEM_TYPE_READ; p.opaque = 8'(b); p.test = 2'd0; p.len = 2'd0;
    p.data = 32'hD000_0000 | 32'(b);
    return p;
  endfunction

  // Response a well-behaved bank would return for a given request.
  function automatic logic [RESP_W-1:0] resp_of(input logic [REQ_W-1:0] m);
    mem_req_4B_t  r;
    mem_resp_4B_t p;
    r = m;
    p.msg_type = r.msg_type; p.opaque = r.opaque; p.test = 2'd0; p.len = r.len;
    p.data = r.data ^ r.addr;
    return p;
  endfunction

  task automatic set_tbl_resps();
    for (int i = 0; i < NB; i++) bankresp_msg[i*RESP_W +: RESP_W] = tbl_resp(i);
  endtask

  mem_resp_4B_t golden[$];
  mem_resp_4B_t bq[NB][$];

  initial begin
    logic [RESP_W-1:0] held;
    logic [REQ_W-1:0]  cur;
    logic [1:0]        b;
    logic [31:0]       a;
    logic              have_cur;
    int                issued;
    int                got;
    int                cyc;

    reset        = 1'b1;
    procreq_val  = 1'b0;
    procreq_msg  = '0;
    procresp_rdy = 1'b1;
    bankreq_rdy  = 4'hF;
    bankresp_val = 4'hF;
    set_tbl_resps();
    #3;
    check("reset procreq_rdy", 64'(procreq_rdy), 64'd1);
    check("reset procresp_val", 64'(procresp_val), 64'd0);
    check("reset bankresp_rdy", 64'(bankresp_rdy), 64'd0);
    check("reset bankreq_val", 64'(bankreq_val), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    //           pv  addr    brdy  bval  prdy e_prdy e_bqv e_pval e_brrdy hb
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h0, 1, 1, 4'b0000, 0, 4'b0000, 0)); // 0 idle
    tv.push_back(mk_vec(1, 32'h10, 4'hF, 4'h0, 1, 1, 4'b0010, 0, 4'b0000, 0)); // 1 req bank1
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h2, 1, 1, 4'b0000, 1, 4'b0010, 1)); // 2 bank1 resp
    tv.push_back(mk_vec(1, 32'h00, 4'hF, 4'h0, 1, 1, 4'b0001, 0, 4'b0000, 0)); // 3
    tv.push_back(mk_vec(1, 32'h10, 4'hF, 4'h4, 1, 1, 4'b0010, 0, 4'b0001, 0)); // 4
    tv.push_back(mk_vec(1, 32'h20, 4'hF, 4'h4, 1, 1, 4'b0100, 0, 4'b0001, 0)); // 5
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h6, 1, 1, 4'b0000, 0, 4'b0001, 0)); // 6
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h7, 1, 1, 4'b0000, 1, 4'b0001, 0)); // 7
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h6, 1, 1, 4'b0000, 1, 4'b0010, 1)); // 8
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h4, 1, 1, 4'b0000, 1, 4'b0100, 2)); // 9
    tv.push_back(mk_vec(1, 32'h30, 4'hF, 4'h8, 1, 1, 4'b1000, 0, 4'b0000, 0)); // 10 no empty bypass
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h8, 1, 1, 4'b0000, 1, 4'b1000, 3)); // 11
    tv.push_back(mk_vec(1, 32'h30, 4'h7, 4'h0, 1, 0, 4'b1000, 0, 4'b0000, 0)); // 12 bank3 busy
    tv.push_back(mk_vec(1, 32'h30, 4'hF, 4'h0, 1, 1, 4'b1000, 0, 4'b0000, 0)); // 13
    tv.push_back(mk_vec(1, 32'h00, 4'hF, 4'h0, 1, 1, 4'b0001, 0, 4'b1000, 0)); // 14
    tv.push_back(mk_vec(1, 32'h10, 4'hF, 4'h0, 1, 1, 4'b0010, 0, 4'b1000, 0)); // 15
    tv.push_back(mk_vec(1, 32'h20, 4'hF, 4'h0, 1, 1, 4'b0100, 0, 4'b1000, 0)); // 16 now full
    tv.push_back(mk_vec(1, 32'h00, 4'hF, 4'h0, 1, 0, 4'b0000, 0, 4'b1000, 0)); // 17 full
    tv.push_back(mk_vec(1, 32'h00, 4'hF, 4'h8, 1, 0, 4'b0000, 1, 4'b1000, 3)); // 18 pop, no bypass
    tv.push_back(mk_vec(1, 32'h00, 4'hF, 4'h0, 1, 1, 4'b0001, 0, 4'b0001, 0)); // 19 accepted
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h1, 0, 0, 4'b0000, 1, 4'b0000, 0)); // 20 proc stall
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h1, 1, 0, 4'b0000, 1, 4'b0001, 0)); // 21
    tv.push_back(mk_vec(1, 32'h20, 4'hF, 4'h2, 1, 1, 4'b0100, 1, 4'b0010, 1)); // 22 push+pop
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h4, 1, 1, 4'b0000, 1, 4'b0100, 2)); // 23
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h5, 1, 1, 4'b0000, 1, 4'b0001, 0)); // 24
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'h4, 1, 1, 4'b0000, 1, 4'b0100, 2)); // 25
    tv.push_back(mk_vec(0, 32'h00, 4'hF, 4'hF, 1, 1, 4'b0000, 0, 4'b0000, 0)); // 26 empty

    for (int k = 0; k < tv.size(); k++) begin
      @(negedge clk);
      procreq_val  = tv[k].pv;
      procreq_msg  = mk_req(MEM_TYPE_READ, 8'(k), tv[k].addr, 32'(k));
      bankreq_rdy  = tv[k].brdy;
      bankresp_val = tv[k].bval;
      procresp_rdy = tv[k].prdy;
      #2;
      check($sformatf("v%0d procreq_rdy", k), 64'(procreq_rdy), 64'(tv[k].e_prdy));
      check($sformatf("v%0d bankreq_val", k), 64'(bankreq_val), 64'(tv[k].e_bqv));
      check($sformatf("v%0d procresp_val", k), 64'(procresp_val), 64'(tv[k].e_pval));
      check($sformatf("v%0d bankresp_rdy", k), 64'(bankresp_rdy), 64'(tv[k].e_brrdy));
      if (tv[k].e_pval)
        check($sformatf("v%0d procresp_msg", k), 64'(procresp_msg), 64'(tbl_resp(tv[k].e_hb)));
      if (tv[k].pv) begin
        a = tv[k].addr;
        b = a[5:4];
        check($sformatf("v%0d bankreq_msg", k), 64'(bankreq_msg[int'(b)*REQ_W +: 64]),
              64'(procreq_msg));
      end
    end

    // Processor stalls for 5 cycles with head bank valid: message held, no pop.
    @(negedge clk);
    procreq_val  = 1'b1;
    procreq_msg  = mk_req(MEM_TYPE_WRITE, 8'h55, 32'h0000_0010, 32'h1234_5678);
    bankreq_rdy  = 4'hF;
    bankresp_val = 4'h0;
    procresp_rdy = 1'b1;
    #2;
    check("stall push rdy", 64'(procreq_rdy), 64'd1);
    @(negedge clk);
    procreq_val  = 1'b0;
    held         = mk_req(MEM_TYPE_WRITE, 8'h55, 32'h0000_0010, 32'h1234_5678) >> 30;
    bankresp_msg[1*RESP_W +: RESP_W] = held;
    bankresp_val = 4'h2;
    procresp_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      check($sformatf("stall%0d procresp_val", c), 64'(procresp_val), 64'd1);
      check($sformatf("stall%0d procresp_msg", c), 64'(procresp_msg), 64'(held));
      check($sformatf("stall%0d bankresp_rdy", c), 64'(bankresp_rdy), 64'd0);
    end
    @(negedge clk);
    procresp_rdy = 1'b1;
    #2;
    check("stall release rdy", 64'(bankresp_rdy), 64'b0010);
    @(negedge clk);
    #2;
    check("stall after pop val", 64'(procresp_val), 64'd0);
    set_tbl_resps();

    // Fill the queue, then reset asynchronously mid-cycle.
    bankresp_val = 4'h0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      procreq_val = 1'b1;
      procreq_msg = mk_req(MEM_TYPE_INIT, 8'(k), 32'(k) << 4, 32'(k));
    end
    @(negedge clk);
    procreq_msg = mk_req(MEM_TYPE_READ, 8'h9, 32'h0, 32'h0);
    #2;
    check("pre-reset full rdy", 64'(procreq_rdy), 64'd0);
    bankresp_val = 4'h1;
    #1;
    reset = 1'b1;
    #1;
    check("async reset procreq_rdy", 64'(procreq_rdy), 64'd1);
    check("async reset procresp_val", 64'(procresp_val), 64'd0);
    check("async reset bankresp_rdy", 64'(bankresp_rdy), 64'd0);
    check("async reset bankreq_val", 64'(bankreq_val), 64'b0001);
    @(negedge clk);
    reset       = 1'b0;
    procreq_val = 1'b0;
    #2;
    check("post reset procresp_val", 64'(procresp_val), 64'd0);

    // Random val/rdy run against an in-order model.
    have_cur = 1'b0;
    issued   = 0;
    got      = 0;
    cyc      = 0;
    cur      = '0;
    while (got < NT && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (!have_cur && issued < NT) begin
        a        = $urandom;
        cur      = mk_req(3'($urandom_range(0, 2)), 8'(issued), a, $urandom);
        have_cur = 1'b1;
      end
      procreq_val  = have_cur && ($urandom_range(0, 3) != 0);
      procreq_msg  = cur;
      bankreq_rdy  = 4'($urandom);
      procresp_rdy = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NB; i++) begin
        bankresp_val[i] = (bq[i].size() > 0) && ($urandom_range(0, 1) == 1);
        bankresp_msg[i*RESP_W +: RESP_W] = (bq[i].size() > 0) ? bq[i][0] : '0;
      end
      #2;
      if (procreq_val && procreq_rdy) begin
        a = cur[REQ_ADDR_LSB +: 32];
        b = a[5:4];
        bq[b].push_back(resp_of(bankreq_msg[int'(b)*REQ_W +: REQ_W]));
        golden.push_back(resp_of(cur));
        issued++;
        have_cur = 1'b0;
      end
      for (int i = 0; i < NB; i++)
        if (bankresp_val[i] && bankresp_rdy[i]) void'(bq[i].pop_front());
      if (procresp_val && procresp_rdy) begin
        if (golden.size() == 0) check("stress spurious resp", 64'(procresp_msg), 64'd0 - 64'd1);
        else check($sformatf("stress resp %0d", got), 64'(procresp_msg), 64'(golden.pop_front()));
        got++;
      end
    end
    check("stress completed", 64'(got), 64'(NT));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
